// File: rtl/reg_lock_pkg.sv
// Shared definitions for the register-lock initiator and the register module it talks to:
// FSM state encoding, default parameters and width helpers.
package reg_lock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_HELD    = 2'd2,
    ST_RELEASE = 2'd3
  } lock_state_e;

  localparam int DEF_NUM_PHY_REGS   = 64;
  localparam int DEF_ID_WIDTH       = 8;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  function automatic int addr_width(input int num_regs);
    return (num_regs < 2) ? 1 : $clog2(num_regs);
  endfunction

  // Wide enough to hold the saturation value TIMEOUT_CYCLES itself.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/reg_lock_initiator_if.sv
// Register-side lock bus: the initiator drives request/release, the register module answers
// with a same-cycle grant and read data.
interface reg_lock_initiator_if
  import reg_lock_pkg::*;
#(
  parameter int ADDR_W   = addr_width(DEF_NUM_PHY_REGS),
  parameter int ID_WIDTH = DEF_ID_WIDTH
);
  logic [ADDR_W-1:0]   sic_addr;
  logic                sic_req_read;
  logic                sic_req_write;
  logic [ID_WIDTH-1:0] sic_issue_id;
  logic                sic_release;
  logic [31:0]         sic_wdata;
  logic [31:0]         sic_rdata_out;
  logic                sic_grant_out;

  modport master (
    output sic_addr, sic_req_read, sic_req_write, sic_issue_id, sic_release, sic_wdata,
    input  sic_rdata_out, sic_grant_out
  );

  modport slave (
    input  sic_addr, sic_req_read, sic_req_write, sic_issue_id, sic_release, sic_wdata,
    output sic_rdata_out, sic_grant_out
  );
endinterface

// File: rtl/lock_wait_timer.sv
// Counts cycles spent waiting for a lock grant; saturates at TIMEOUT_CYCLES and flags
// expiry on the last allowed waiting cycle. TIMEOUT_CYCLES=0 never expires.
module lock_wait_timer
  import reg_lock_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int               CNT_W    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit               TIMER_ON = (TIMEOUT_CYCLES != 0);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: default first so every path assigns count_d; otherwise a latch is inferred.
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = TIMER_ON && (count_q == CNT_LAST);

endmodule

// File: rtl/reg_lock_initiator.sv
// Lock initiator: takes one command, requests the register lock, optionally holds it until
// unlock/flush, releases it and reports done/aborted/timeout with registered status outputs.
module reg_lock_initiator
  import reg_lock_pkg::*;
#(
  parameter int NUM_PHY_REGS   = DEF_NUM_PHY_REGS,
  parameter int ID_WIDTH       = DEF_ID_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int ADDR_W        = addr_width(NUM_PHY_REGS)
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic                cmd_flash,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [ID_WIDTH-1:0] cmd_id,
  input  logic [31:0]         cmd_wdata,

  input  logic                unlock,
  input  logic [31:0]         unlock_wdata,
  input  logic                flush,

  output logic                held,
  output logic                rdata_valid,
  output logic [31:0]         rdata,
  output logic                done,
  output logic                aborted,
  output logic                timeout,
  output logic                proto_err,

  reg_lock_initiator_if.master sic
);

  lock_state_e         state_q, state_d;
  logic                write_q, write_d;
  logic                flash_q, flash_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                flush_pend_q, flush_pend_d;
  logic                abort_q, abort_d;

  logic                cmd_ready_q, cmd_ready_d;
  logic                held_q, held_d;
  logic                rdata_valid_q, rdata_valid_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;
  logic                timeout_q, timeout_d;
  logic                proto_err_q, proto_err_d;
  logic                req_rd_q, req_rd_d;
  logic                req_wr_q, req_wr_d;
  logic                release_q, release_d;

  logic                grant;
  logic                expire;

  assign grant = sic.sic_grant_out;

  lock_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q != ST_REQ),
    .enable ((state_q == ST_REQ) && !grant),
    .expire (expire)
  );

  always_comb begin
    state_d       = state_q;
    write_d       = write_q;
    flash_d       = flash_q;
    addr_d        = addr_q;
    id_d          = id_q;
    wdata_d       = wdata_q;
    flush_pend_d  = flush_pend_q;
    abort_d       = abort_q;
    rdata_d       = rdata_q;
    proto_err_d   = proto_err_q;
    rdata_valid_d = 1'b0;
    done_d        = 1'b0;
    aborted_d     = 1'b0;
    timeout_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          write_d      = cmd_write;
          flash_d      = cmd_flash;
          addr_d       = cmd_addr;
          id_d         = cmd_id;
          wdata_d      = cmd_wdata;
          flush_pend_d = 1'b0;
          abort_d      = 1'b0;
          state_d      = ST_REQ;
        end
      end
      ST_REQ: begin
        // Grant wins over a coincident flush or timeout; a flush seen here is replayed in HELD.
        if (grant) begin
          if (!write_q) rdata_d = sic.sic_rdata_out;
          rdata_valid_d = !write_q;
          if (flash_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d      = ST_HELD;
            flush_pend_d = flush;
          end
        end else if (flush) begin
          state_d   = ST_IDLE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (expire) begin
          state_d   = ST_IDLE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
          timeout_d = 1'b1;
        end
      end
      ST_HELD: begin
        if (!grant) proto_err_d = 1'b1;
        if (unlock || flush || flush_pend_q) begin
          state_d = ST_RELEASE;
          abort_d = flush || flush_pend_q;
          if (unlock && write_q) wdata_d = unlock_wdata;
        end
      end
      ST_RELEASE: begin
        if (!grant) proto_err_d = 1'b1;
        state_d   = ST_IDLE;
        done_d    = 1'b1;
        aborted_d = abort_q;
      end
      default: state_d = ST_IDLE;
    endcase

    // Bus-side outputs are registered from the next state so they line up with state_q.
    cmd_ready_d = (state_d == ST_IDLE);
    held_d      = (state_d == ST_HELD);
    req_wr_d    = (state_d != ST_IDLE) && write_d;
    req_rd_d    = (state_d != ST_IDLE) && !write_d;
    release_d   = (state_d == ST_RELEASE) || ((state_d == ST_REQ) && flash_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: datapath registers are reset too, so the bus reads all-zero right after reset.
      state_q       <= ST_IDLE;
      write_q       <= 1'b0;
      flash_q       <= 1'b0;
      addr_q        <= '0;
      id_q          <= '0;
      wdata_q       <= '0;
      flush_pend_q  <= 1'b0;
      abort_q       <= 1'b0;
      cmd_ready_q   <= 1'b1;
      held_q        <= 1'b0;
      rdata_valid_q <= 1'b0;
      rdata_q       <= '0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      timeout_q     <= 1'b0;
      proto_err_q   <= 1'b0;
      req_rd_q      <= 1'b0;
      req_wr_q      <= 1'b0;
      release_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      write_q       <= write_d;
      flash_q       <= flash_d;
      addr_q        <= addr_d;
      id_q          <= id_d;
      wdata_q       <= wdata_d;
      flush_pend_q  <= flush_pend_d;
      abort_q       <= abort_d;
      cmd_ready_q   <= cmd_ready_d;
      held_q        <= held_d;
      rdata_valid_q <= rdata_valid_d;
      rdata_q       <= rdata_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
      timeout_q     <= timeout_d;
      proto_err_q   <= proto_err_d;
      req_rd_q      <= req_rd_d;
      req_wr_q      <= req_wr_d;
      release_q     <= release_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign held        = held_q;
  assign rdata_valid = rdata_valid_q;
  assign rdata       = rdata_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign timeout     = timeout_q;
  assign proto_err   = proto_err_q;

  assign sic.sic_addr      = addr_q;
  assign sic.sic_issue_id  = id_q;
  assign sic.sic_wdata     = wdata_q;
  assign sic.sic_req_read  = req_rd_q;
  assign sic.sic_req_write = req_wr_q;
  assign sic.sic_release   = release_q;

endmodule

// File: tb/tb_reg_lock_initiator.sv
// Directed bench for reg_lock_initiator: completion expectations are queued when a command
// is issued and checked when done appears; bus behaviour is checked cycle by cycle.
module tb_reg_lock_initiator;
  localparam int NREGS = 64;
  localparam int IDW   = 8;
  localparam int TMO   = 4;
  localparam int AW    = $clog2(NREGS);

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid, cmd_ready, cmd_write, cmd_flash;
  logic [AW-1:0]   cmd_addr;
  logic [IDW-1:0]  cmd_id;
  logic [31:0]     cmd_wdata;
  logic            unlock, flush;
  logic [31:0]     unlock_wdata;
  logic            held, rdata_valid, done, aborted, timeout, proto_err;
  logic [31:0]     rdata;

  always #5 clk = ~clk;

  reg_lock_initiator_if #(.ADDR_W(AW), .ID_WIDTH(IDW)) sic_bus ();

  reg_lock_initiator #(
    .NUM_PHY_REGS   (NREGS),
    .ID_WIDTH       (IDW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_flash    (cmd_flash),
    .cmd_addr     (cmd_addr),
    .cmd_id       (cmd_id),
    .cmd_wdata    (cmd_wdata),
    .unlock       (unlock),
    .unlock_wdata (unlock_wdata),
    .flush        (flush),
    .held         (held),
    .rdata_valid  (rdata_valid),
    .rdata        (rdata),
    .done         (done),
    .aborted      (aborted),
    .timeout      (timeout),
    .proto_err    (proto_err),
    .sic          (sic_bus)
  );

  typedef struct packed {
    logic        rv;
    logic [31:0] rdata;
    logic        aborted;
    logic        timeout;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic rv, input logic [31:0] rd, input logic ab, input logic to);
    exp_t e;
    e.rv = rv; e.rdata = rd; e.aborted = ab; e.timeout = to;
    exp_q.push_back(e);
  endtask

  task automatic issue(input string tag, input logic wr, input logic fl, input logic [AW-1:0] a,
                       input logic [IDW-1:0] id, input logic [31:0] wd);
    check_b({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    cmd_write = wr; cmd_flash = fl; cmd_addr = a; cmd_id = id; cmd_wdata = wd;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    exp_t e;
    int   n = 0;
    while (done !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    check_b({tag, "_done"}, done, 1'b1);
    check_b({tag, "_sb_has_entry"}, exp_q.size() > 0, 1'b1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_b({tag, "_rdata_valid"}, rdata_valid, e.rv);
      check  ({tag, "_rdata"},       rdata,       e.rdata);
      check_b({tag, "_aborted"},     aborted,     e.aborted);
      check_b({tag, "_timeout"},     timeout,     e.timeout);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_flash = 1'b0;
    cmd_addr = '0; cmd_id = '0; cmd_wdata = '0;
    unlock = 1'b0; unlock_wdata = '0; flush = 1'b0;
    sic_bus.sic_grant_out = 1'b0;
    sic_bus.sic_rdata_out = '0;
    tick();
    tick();
    check_b("rst_cmd_ready", cmd_ready, 1'b1);
    check_b("rst_held",      held,      1'b0);
    check_b("rst_done",      done,      1'b0);
    check_b("rst_proto_err", proto_err, 1'b0);
    check  ("rst_rdata",     rdata,     32'h0);
    check_b("rst_req_read",  sic_bus.sic_req_read,  1'b0);
    check_b("rst_req_write", sic_bus.sic_req_write, 1'b0);
    check_b("rst_release",   sic_bus.sic_release,   1'b0);
    check  ("rst_wdata",     sic_bus.sic_wdata,     32'h0);
    rst = 1'b0;
    tick();

    // Flash write, granted in the first REQ cycle.
    issue("t1", 1'b1, 1'b1, AW'(4), IDW'(10), 32'h4444_4444);
    check_b("t1_req_write", sic_bus.sic_req_write, 1'b1);
    check_b("t1_req_read",  sic_bus.sic_req_read,  1'b0);
    check_b("t1_release",   sic_bus.sic_release,   1'b1);
    check  ("t1_addr",      32'(sic_bus.sic_addr),     32'd4);
    check  ("t1_id",        32'(sic_bus.sic_issue_id), 32'd10);
    check  ("t1_wdata",     sic_bus.sic_wdata,     32'h4444_4444);
    check_b("t1_busy",      cmd_ready,             1'b0);
    sic_bus.sic_grant_out = 1'b1;
    push_exp(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    sic_bus.sic_grant_out = 1'b0;
    wait_done("t1", 0);
    check_b("t1_post_release", sic_bus.sic_release,   1'b0);
    check_b("t1_post_req",     sic_bus.sic_req_write, 1'b0);

    // Back-to-back read; grant withheld 3 cycles, then given on the would-be timeout cycle.
    issue("t2", 1'b0, 1'b0, AW'(10), IDW'(100), 32'h0);
    check_b("t2_release_off", sic_bus.sic_release, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_b("t2_wait_req", sic_bus.sic_req_read, 1'b1);
      tick();
    end
    check_b("t2_still_req", sic_bus.sic_req_read, 1'b1);
    sic_bus.sic_grant_out = 1'b1;
    sic_bus.sic_rdata_out = 32'hCAFE_BABE;
    tick();
    sic_bus.sic_rdata_out = 32'h0;
    check_b("t2_held",        held,        1'b1);
    check_b("t2_rdata_valid", rdata_valid, 1'b1);
    check  ("t2_rdata",       rdata,       32'hCAFE_BABE);
    check_b("t2_no_timeout",  timeout,     1'b0);
    check_b("t2_no_done",     done,        1'b0);
    check_b("t2_held_norel",  sic_bus.sic_release, 1'b0);
    tick();
    check_b("t2_rv_pulse",    rdata_valid, 1'b0);
    check_b("t2_held2",       held,        1'b1);
    unlock = 1'b1;
    tick();
    unlock = 1'b0;
    check_b("t2_rel",         sic_bus.sic_release,  1'b1);
    check_b("t2_rel_req",     sic_bus.sic_req_read, 1'b1);
    check_b("t2_rel_unheld",  held,                 1'b0);
    push_exp(1'b0, 32'hCAFE_BABE, 1'b0, 1'b0);
    tick();
    wait_done("t2", 0);
    check_b("t2_post_release", sic_bus.sic_release,  1'b0);
    check_b("t2_post_req",     sic_bus.sic_req_read, 1'b0);

    // Held write; unlock supplies the final write data.
    issue("t3", 1'b1, 1'b0, AW'(7), IDW'(90), 32'h1111_2222);
    tick();
    check_b("t3_held",   held,              1'b1);
    check  ("t3_wdata0", sic_bus.sic_wdata, 32'h1111_2222);
    check_b("t3_no_rv",  rdata_valid,       1'b0);
    unlock = 1'b1;
    unlock_wdata = 32'h1501_1501;
    tick();
    unlock = 1'b0;
    check_b("t3_rel",       sic_bus.sic_release,   1'b1);
    check  ("t3_wdata",     sic_bus.sic_wdata,     32'h1501_1501);
    check_b("t3_rel_write", sic_bus.sic_req_write, 1'b1);
    check  ("t3_id",        32'(sic_bus.sic_issue_id), 32'd90);
    push_exp(1'b0, 32'hCAFE_BABE, 1'b0, 1'b0);
    tick();
    wait_done("t3", 0);
    sic_bus.sic_grant_out = 1'b0;
    check_b("t3_proto_ok", proto_err, 1'b0);

    // Grant never comes: timeout after TMO REQ cycles; stray cmd_valid/unlock are ignored.
    issue("t4", 1'b0, 1'b0, AW'(1), IDW'(5), 32'h0);
    cmd_valid = 1'b1;
    cmd_addr  = AW'(20);
    unlock    = 1'b1;
    check_b("t4_busy", cmd_ready, 1'b0);
    push_exp(1'b0, 32'hCAFE_BABE, 1'b1, 1'b1);
    for (int i = 0; i < TMO; i++) begin
      check_b("t4_req",   sic_bus.sic_req_read, 1'b1);
      check_b("t4_norel", sic_bus.sic_release,  1'b0);
      tick();
      cmd_valid = 1'b0;
    end
    unlock = 1'b0;
    wait_done("t4", 0);
    check_b("t4_withdrawn", sic_bus.sic_req_read, 1'b0);
    check_b("t4_norel_end", sic_bus.sic_release,  1'b0);
    check  ("t4_addr_kept", 32'(sic_bus.sic_addr), 32'd1);

    // Flush while waiting: withdraw without release.
    issue("t5", 1'b1, 1'b0, AW'(2), IDW'(3), 32'h2222);
    flush = 1'b1;
    push_exp(1'b0, 32'hCAFE_BABE, 1'b1, 1'b0);
    tick();
    flush = 1'b0;
    wait_done("t5", 0);
    check_b("t5_norel", sic_bus.sic_release,   1'b0);
    check_b("t5_noreq", sic_bus.sic_req_write, 1'b0);
    check_b("t5_held",  held,                  1'b0);

    // Flush coincides with grant: one HELD cycle, then RELEASE; grant drop flags proto_err.
    issue("t6", 1'b1, 1'b0, AW'(3), IDW'(33), 32'hA5A5_A5A5);
    sic_bus.sic_grant_out = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sic_bus.sic_grant_out = 1'b0;
    check_b("t6_held",      held,      1'b1);
    check_b("t6_no_done",   done,      1'b0);
    check_b("t6_proto_pre", proto_err, 1'b0);
    tick();
    check_b("t6_rel",       sic_bus.sic_release, 1'b1);
    check  ("t6_wdata",     sic_bus.sic_wdata,   32'hA5A5_A5A5);
    check_b("t6_proto_err", proto_err,           1'b1);
    push_exp(1'b0, 32'hCAFE_BABE, 1'b1, 1'b0);
    tick();
    wait_done("t6", 0);
    tick();
    tick();
    check_b("t6_proto_sticky", proto_err, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_b("t6_proto_clr", proto_err, 1'b0);
    check  ("t6_rdata_clr", rdata,     32'h0);

    // Reset while the lock is held: no release is emitted.
    issue("t7", 1'b1, 1'b0, AW'(5), IDW'(7), 32'h77);
    sic_bus.sic_grant_out = 1'b1;
    tick();
    check_b("t7_held", held, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sic_bus.sic_grant_out = 1'b0;
    check_b("t7_norel",     sic_bus.sic_release,   1'b0);
    check_b("t7_noreq",     sic_bus.sic_req_write, 1'b0);
    check_b("t7_unheld",    held,                  1'b0);
    check_b("t7_cmd_ready", cmd_ready,             1'b1);
    tick();
    check_b("t7_no_done",   done,                  1'b0);
    check_b("t7_norel2",    sic_bus.sic_release,   1'b0);

    // Flash read: rdata_valid pulses together with done.
    issue("t8", 1'b0, 1'b1, AW'(9), IDW'(1), 32'h0);
    check_b("t8_rel",  sic_bus.sic_release,  1'b1);
    check_b("t8_read", sic_bus.sic_req_read, 1'b1);
    sic_bus.sic_grant_out = 1'b1;
    sic_bus.sic_rdata_out = 32'h1234_5678;
    push_exp(1'b1, 32'h1234_5678, 1'b0, 1'b0);
    tick();
    sic_bus.sic_grant_out = 1'b0;
    sic_bus.sic_rdata_out = 32'h0;
    wait_done("t8", 0);
    tick();
    check_b("t8_rv_pulse", rdata_valid, 1'b0);
    check_b("t8_done_pulse", done, 1'b0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_lock_initiator.md
REG_LOCK_INITIATOR -- requirements
Module: reg_lock_initiator

Interface
REQ-001 SHALL have parameter NUM_PHY_REGS, default 64, number of physical registers addressed.
REQ-002 SHALL have parameter ID_WIDTH, default 8, issue-ID width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum cycles spent waiting for grant; 0 disables the timeout.
REQ-004 SHALL have ports: clk  in  1  single clock; rst  in  1  synchronous reset, active-high.
REQ-005 SHALL have ports: cmd_valid in 1, cmd_ready out 1, cmd_write in 1 (1=write, 0=read), cmd_flash in 1 (request+release in one grant cycle), cmd_addr in $clog2(NUM_PHY_REGS), cmd_id in ID_WIDTH, cmd_wdata in 32.
REQ-006 SHALL have ports: unlock in 1 (release held lock), unlock_wdata in 32 (final write data), flush in 1 (abort).
REQ-007 SHALL have ports: held out 1, rdata_valid out 1, rdata out 32, done out 1, aborted out 1, timeout out 1, proto_err out 1 (sticky).
REQ-008 SHALL have register-side ports: sic_addr out, sic_req_read out 1, sic_req_write out 1, sic_issue_id out ID_WIDTH, sic_release out 1, sic_wdata out 32, sic_rdata_out in 32, sic_grant_out in 1 (grant is combinational, same cycle as request).

Function
REQ-009 SHALL implement FSM states IDLE, REQ, HELD, RELEASE.
REQ-010 IDLE: cmd_ready=1; cmd_valid at an edge captures addr/id/write/flash/wdata and moves to REQ; no sic_req_* asserted.
REQ-011 REQ: drive sic_req_write=cmd_write, sic_req_read=!cmd_write, captured addr/id/wdata; sic_release=cmd_flash.
REQ-012 REQ with grant and flash: next state IDLE; done pulses 1 cycle after that edge; for reads rdata=sic_rdata_out sampled at that edge, rdata_valid pulses with done.
REQ-013 REQ with grant and no flash: next state HELD; read data captured at the grant edge, rdata_valid pulses in the first HELD cycle.
REQ-014 REQ without grant: remain; wait counter increments, saturating at TIMEOUT_CYCLES.
REQ-015 REQ timeout (counter==TIMEOUT_CYCLES-1, no grant, TIMEOUT_CYCLES!=0): withdraw request (no release) at that edge, go IDLE, timeout and aborted pulse with done.
REQ-016 REQ flush without grant: withdraw without release, go IDLE, done+aborted pulse.
REQ-017 Grant SHALL take precedence over simultaneous flush or timeout in REQ; a flush coinciding with grant is remembered and forces RELEASE on the next cycle.
REQ-018 HELD: held=1; keep request asserted, sic_release=0; unlock or pending/new flush moves to RELEASE; unlock_wdata captured into sic_wdata for writes.
REQ-019 RELEASE: request + sic_release=1 for exactly one cycle, then IDLE with done pulse; aborted=1 if entered via flush.
REQ-020 sic_grant_out=0 while in HELD or RELEASE SHALL set proto_err (cleared only by rst); FSM proceeds regardless.
REQ-021 cmd_valid outside IDLE SHALL be ignored (cmd_ready=0); unlock outside HELD ignored.
REQ-022 Back-to-back: cmd_valid in the IDLE cycle following done SHALL be accepted (minimum 2-cycle turnaround per flash op).

Reset
REQ-023 Synchronous rst SHALL force IDLE and, after that edge: all sic_* outputs, held, rdata_valid, done, aborted, timeout, proto_err =0; rdata=0; counter=0.
REQ-024 Reset mid-operation SHALL NOT emit a release; the register module SHALL be reset in the same cycle.

Structure
REQ-025 Package reg_lock_pkg SHALL hold the state enum and default parameter constants shared with register_module.
REQ-026 Wait counter SHALL be a sub-module lock_wait_timer (clear, enable, saturate, expire output).

Verification
REQ-027 Flash write addr 4, id 10, wdata 0x44444444, grant in first REQ cycle -> release asserted same cycle, done 1 cycle later, aborted=0.
REQ-028 Read addr 10 id 100, grant withheld 3 cycles then given with rdata 0xCAFEBABE -> HELD, rdata_valid with rdata=0xCAFEBABE; unlock -> one RELEASE cycle, done.
REQ-029 Write id 90 held, unlock with unlock_wdata 0x15011501 -> sic_wdata=0x15011501 and sic_release=1 in the RELEASE cycle.
REQ-030 TIMEOUT_CYCLES=4, grant never -> request withdrawn after 4 REQ cycles, release never asserted, timeout+aborted+done pulse.
REQ-031 flush and grant in same REQ cycle -> HELD for one cycle, then RELEASE, done+aborted; grant dropped in HELD -> proto_err=1 until rst.
